operand_fetch: RTL and testbench
================================

// Module: operand_fetch
// PURPOSE
//  Issue stage directly upstream of register_bank consumers: accepts decoded instructions, drives the
//  bank's three read indices, captures operands into an output register and hands them to execute.
//  Snoops the bank's write port to bypass same-cycle writebacks and keeps a 16-entry pending-write
//  scoreboard. Stalls on RAW/WAW hazards against in-flight results.
// PARAMETERS
//  OP_W  8  width of opaque decoded-op field carried through unchanged
// PORTS
//  clk          in   1     clock, all state on posedge
//  rst_async_n  in   1     asynchronous active-low reset
//  in_valid     in   1     decoded instruction present
//  in_ready     out  1     stage accepts in_* this cycle
//  in_op        in   OP_W  decoded op, passed through
//  in_ra/rb/rc  in   4     source register indices
//  in_rd        in   4     destination index
//  in_wr        in   1     instruction writes in_rd
//  rf_a/b/c_index out 4    to register bank read indices (= in_ra/rb/rc, combinational)
//  rf_a/b/c     in   32    register bank read data
//  wb_en        in   1     writeback this cycle (same signals as bank write port)
//  wb_index     in   4     writeback destination
//  wb_data      in   32    writeback data
//  flush        in   1     kill held output instruction
//  out_valid    out  1     operands valid toward execute
//  out_ready    in   1     execute accepts this cycle
//  out_op       out  OP_W  registered op
//  out_rd       out  4     registered destination
//  out_wr       out  1     registered write flag
//  out_a/b/c    out  32    registered operand values
// BEHAVIOUR
//  Reset: out_valid=0, out_op/out_rd/out_wr/out_a/b/c=0, pending[15:0]=0. in_ready follows rule below.
//  wb_hit(x) = wb_en && wb_index==x && x!=0. Writes to index 0 are ignored everywhere.
//  Operand select: wb_hit(src) ? wb_data : rf_src (bank updates only at edge, so bypass is required).
//  Hazard(src) = pending[src] && !wb_hit(src); index 0 never pending.
//  stall = in_valid && (Hazard(ra)||Hazard(rb)||Hazard(rc)||(in_wr && Hazard(rd))).
//  in_ready = (!out_valid || out_ready) && !stall && !flush. Purely combinational, no state machine
//   beyond the output holding register (states: EMPTY out_valid=0, FULL out_valid=1).
//  Accept (in_valid&&in_ready): next edge load out_* with selected operands, out_valid=1. Latency 1.
//  FULL && out_ready && !accept: out_valid->0. FULL && !out_ready: all out_* held stable.
//  Scoreboard per edge, index i!=0: clear if wb_hit(i); set if accept && in_wr && in_rd==i.
//   Set and clear same index same cycle: set wins (new writer outstanding).
//   WAW stall guarantees at most one outstanding writer per index; single bit suffices.
//  flush: next edge out_valid=0; if held instruction had out_wr && out_rd!=0, clear pending[out_rd]
//   (unless same index also set same edge - cannot occur since in_ready=0 during flush).
//   Flush with out_valid=0: no effect. Flush does not touch in-flight writers downstream.
//  out_valid && out_ready && flush together: flush dominates (instruction dropped, pending cleared).
//  Reset mid-operation: immediate drop of held instruction, pending cleared, out_* zeroed.
// TESTING
//  Reset low, then issue ra=1,rb=2,rc=0 with rf_a=5,rf_b=7 -> 1 cycle later out_valid=1, out_a=5, out_b=7, out_c=0.
//  Issue rd=3 in_wr=1, then next instr ra=3 -> in_ready=0 until wb_en,wb_index=3,wb_data=0x1234; that cycle accepted, out_a=0x1234 (bypass).
//  out_ready=0 for 4 cycles while FULL -> out_* stable, in_ready=0; release -> new instr loads on following edge, no bubble.
//  Issue rd=4 in_wr=1 same cycle wb_en,wb_index=4 from older writer -> pending[4]=1 afterward; second writer to rd=4 stalls (WAW).
//  Held instr rd=6 in_wr=1, assert flush -> out_valid=0, pending[6]=0; dependent instr ra=6 accepted next cycle.
//  wb_en with wb_index=0, wb_data=0xFFFF, instr ra=0 -> out_a=rf_a (no bypass), no stall.

Source files
------------

// File: rtl/operand_fetch.sv
// Operand fetch / issue stage. It drives the register bank read indices and bypasses same-cycle
// writebacks. A pending-write scoreboard stalls RAW/WAW hazards, and the fetched operands are
// registered toward execute.
module operand_fetch #(
    parameter int OP_W = 8
) (
    input  logic            clk,
    input  logic            rst_async_n,

    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] in_op,
    input  logic [3:0]      in_ra,
    input  logic [3:0]      in_rb,
    input  logic [3:0]      in_rc,
    input  logic [3:0]      in_rd,
    input  logic            in_wr,

    output logic [3:0]      rf_a_index,
    output logic [3:0]      rf_b_index,
    output logic [3:0]      rf_c_index,
    input  logic [31:0]     rf_a,
    input  logic [31:0]     rf_b,
    input  logic [31:0]     rf_c,

    input  logic            wb_en,
    input  logic [3:0]      wb_index,
    input  logic [31:0]     wb_data,

    input  logic            flush,

    output logic            out_valid,
    input  logic            out_ready,
    output logic [OP_W-1:0] out_op,
    output logic [3:0]      out_rd,
    output logic            out_wr,
    output logic [31:0]     out_a,
    output logic [31:0]     out_b,
    output logic [31:0]     out_c
);

    logic [15:0] pending;
    logic [15:0] pending_nxt;
    logic [15:0] wb_hit;
    logic [31:0] sel_a, sel_b, sel_c;
    logic        haz_a, haz_b, haz_c, haz_d;
    logic        stall;
    logic        accept;
    logic        flush_clear;

    assign rf_a_index = in_ra;
    assign rf_b_index = in_rb;
    assign rf_c_index = in_rc;

    // A one-hot vector of the register index that the bank writes this cycle. Index 0 is never hit.
    always_comb begin
        // NOTE: default first so every path assigns the vector; no latch is inferred
        wb_hit = '0;
        if (wb_en && (wb_index != 4'd0))
            wb_hit[wb_index] = 1'b1;
    end

    // The bank only updates at the clock edge, so a same-cycle writeback must be forwarded here.
    assign sel_a = wb_hit[in_ra] ? wb_data : rf_a;
    assign sel_b = wb_hit[in_rb] ? wb_data : rf_b;
    assign sel_c = wb_hit[in_rc] ? wb_data : rf_c;

    assign haz_a = pending[in_ra] && !wb_hit[in_ra];
    assign haz_b = pending[in_rb] && !wb_hit[in_rb];
    assign haz_c = pending[in_rc] && !wb_hit[in_rc];
    assign haz_d = in_wr && pending[in_rd] && !wb_hit[in_rd];

    assign stall    = in_valid && (haz_a || haz_b || haz_c || haz_d);
    assign in_ready = (!out_valid || out_ready) && !stall && !flush;
    assign accept   = in_valid && in_ready;

    assign flush_clear = flush && out_valid && out_wr && (out_rd != 4'd0);

    // Clears are applied before sets, so a new writer stays outstanding when its index is
    // retired in the same cycle.
    always_comb begin
        pending_nxt = pending & ~wb_hit;
        if (flush_clear)
            pending_nxt[out_rd] = 1'b0;
        if (accept && in_wr && (in_rd != 4'd0))
            pending_nxt[in_rd] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            // NOTE: sequential state uses non-blocking assignments only
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            out_valid <= 1'b0;
            out_op    <= '0;
            out_rd    <= '0;
            out_wr    <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_c     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_op    <= in_op;
            out_rd    <= in_rd;
            out_wr    <= in_wr;
            out_a     <= sel_a;
            out_b     <= sel_b;
            out_c     <= sel_c;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch. It covers issue latency, writeback bypass, backpressure,
// WAW stall, flush, writes to index 0 and reset taken mid-operation.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst_async_n;
    logic        in_valid, in_ready, in_wr;
    logic [7:0]  in_op;
    logic [3:0]  in_ra, in_rb, in_rc, in_rd;
    logic [3:0]  rf_a_index, rf_b_index, rf_c_index;
    logic [31:0] rf_a, rf_b, rf_c;
    logic        wb_en;
    logic [3:0]  wb_index;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid, out_ready, out_wr;
    logic [7:0]  out_op;
    logic [3:0]  out_rd;
    logic [31:0] out_a, out_b, out_c;

    int n_tests = 0;
    int n_fail  = 0;

    operand_fetch #(.OP_W(8)) dut (
        .clk(clk), .rst_async_n(rst_async_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_ra(in_ra), .in_rb(in_rb), .in_rc(in_rc), .in_rd(in_rd), .in_wr(in_wr),
        .rf_a_index(rf_a_index), .rf_b_index(rf_b_index), .rf_c_index(rf_c_index),
        .rf_a(rf_a), .rf_b(rf_b), .rf_c(rf_c),
        .wb_en(wb_en), .wb_index(wb_index), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .out_rd(out_rd), .out_wr(out_wr),
        .out_a(out_a), .out_b(out_b), .out_c(out_c)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled after they settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] op, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [3:0] rc, input logic [3:0] rd, input logic wr);
        in_valid = 1'b1;
        in_op = op; in_ra = ra; in_rb = rb; in_rc = rc; in_rd = rd; in_wr = wr;
    endtask

    initial begin
        rst_async_n = 1'b0;
        in_valid = 1'b0; in_op = '0; in_ra = '0; in_rb = '0; in_rc = '0; in_rd = '0; in_wr = 1'b0;
        rf_a = '0; rf_b = '0; rf_c = '0;
        wb_en = 1'b0; wb_index = '0; wb_data = '0;
        flush = 1'b0; out_ready = 1'b1;

        // Reset state
        tick();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_a", out_a, 32'd0);
        check("rst_out_rd", {28'd0, out_rd}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_async_n = 1'b1;
        tick();

        // Basic issue with latency 1
        issue(8'h11, 4'd1, 4'd2, 4'd0, 4'd0, 1'b0);
        rf_a = 32'd5; rf_b = 32'd7; rf_c = 32'd0;
        #1;
        check("basic_in_ready", {31'd0, in_ready}, 32'd1);
        check("basic_rf_a_index", {28'd0, rf_a_index}, 32'd1);
        check("basic_rf_b_index", {28'd0, rf_b_index}, 32'd2);
        tick();
        check("basic_out_valid", {31'd0, out_valid}, 32'd1);
        check("basic_out_a", out_a, 32'd5);
        check("basic_out_b", out_b, 32'd7);
        check("basic_out_c", out_c, 32'd0);
        check("basic_out_op", {24'd0, out_op}, 32'h11);

        // RAW stall until writeback, then bypass
        issue(8'h22, 4'd0, 4'd0, 4'd0, 4'd3, 1'b1);
        rf_a = 32'd0; rf_b = 32'd0;
        tick();
        check("raw_writer_out_rd", {28'd0, out_rd}, 32'd3);
        issue(8'h33, 4'd3, 4'd0, 4'd0, 4'd0, 1'b0);
        rf_a = 32'hDEAD;
        #1;
        check("raw_stall0", {31'd0, in_ready}, 32'd0);
        tick();
        check("raw_stall1", {31'd0, in_ready}, 32'd0);
        tick();
        check("raw_stall2", {31'd0, in_ready}, 32'd0);
        wb_en = 1'b1; wb_index = 4'd3; wb_data = 32'h1234;
        #1;
        check("raw_wb_ready", {31'd0, in_ready}, 32'd1);
        tick();
        wb_en = 1'b0;
        check("raw_bypass_valid", {31'd0, out_valid}, 32'd1);
        check("raw_bypass_a", out_a, 32'h1234);

        // Backpressure: output held stable for 4 cycles
        out_ready = 1'b0;
        issue(8'h44, 4'd5, 4'd0, 4'd0, 4'd0, 1'b0);
        rf_a = 32'hAA;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_out_a", out_a, 32'h1234);
            check("bp_out_op", {24'd0, out_op}, 32'h33);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("bp_nobubble_valid", {31'd0, out_valid}, 32'd1);
        check("bp_nobubble_a", out_a, 32'hAA);
        check("bp_nobubble_op", {24'd0, out_op}, 32'h44);

        // WAW: the set from a new writer wins over a clear from the same cycle's writeback
        issue(8'h50, 4'd0, 4'd0, 4'd0, 4'd4, 1'b1);
        tick();
        issue(8'h51, 4'd0, 4'd0, 4'd0, 4'd4, 1'b1);
        wb_en = 1'b1; wb_index = 4'd4; wb_data = 32'h4444;
        #1;
        check("waw_second_ready", {31'd0, in_ready}, 32'd1);
        tick();
        wb_en = 1'b0;
        issue(8'h52, 4'd0, 4'd0, 4'd0, 4'd4, 1'b1);
        #1;
        check("waw_third_stall", {31'd0, in_ready}, 32'd0);
        issue(8'h53, 4'd4, 4'd0, 4'd0, 4'd0, 1'b0);
        #1;
        check("raw4_stall", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        wb_en = 1'b1; wb_index = 4'd4;
        tick();
        wb_en = 1'b0;
        issue(8'h53, 4'd4, 4'd0, 4'd0, 4'd0, 1'b0);
        #1;
        check("raw4_cleared", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
        tick();

        // Flush a held writer with out_ready high; the flush takes priority
        out_ready = 1'b0;
        issue(8'h60, 4'd0, 4'd0, 4'd0, 4'd6, 1'b1);
        tick();
        check("flush_held_rd", {28'd0, out_rd}, 32'd6);
        issue(8'h61, 4'd6, 4'd0, 4'd0, 4'd0, 1'b0);
        rf_a = 32'h66;
        #1;
        check("flush_dep_stall", {31'd0, in_ready}, 32'd0);
        flush = 1'b1; out_ready = 1'b1;
        #1;
        check("flush_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        flush = 1'b0;
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        #1;
        check("flush_dep_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("flush_dep_valid", {31'd0, out_valid}, 32'd1);
        check("flush_dep_a", out_a, 32'h66);

        // A writeback to index 0 is neither bypassed nor a cause of stall
        issue(8'h70, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        rf_a = 32'h77;
        wb_en = 1'b1; wb_index = 4'd0; wb_data = 32'hFFFF;
        #1;
        check("r0_ready", {31'd0, in_ready}, 32'd1);
        tick();
        wb_en = 1'b0;
        check("r0_no_bypass", out_a, 32'h77);

        // Reset taken mid-operation
        out_ready = 1'b0;
        issue(8'h80, 4'd0, 4'd0, 4'd0, 4'd7, 1'b1);
        rf_a = 32'h88;
        tick();
        rst_async_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_out_a", out_a, 32'd0);
        check("midrst_out_wr", {31'd0, out_wr}, 32'd0);
        rst_async_n = 1'b1;
        out_ready = 1'b1;
        issue(8'h81, 4'd7, 4'd0, 4'd0, 4'd0, 1'b0);
        #1;
        check("midrst_pending_cleared", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("midrst_issue_valid", {31'd0, out_valid}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
